// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
//  N-input interrupt/event priority encoder with sticky request capture,
//  per-source masking and a valid/ready grant handshake. Fixed priority
//  (highest index wins) or round-robin selection by MODE.
//
//  Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   req        in   N   request lines; a high cycle sets pending[i]
//   mask       in   N   1 = source enabled; masked sources stay pending
//   out_idx    out  W   granted source index, meaningful while out_valid=1
//   out_valid  out  1   grant presented
//   out_ready  in   1   consumer accepts when out_valid && out_ready
//   pending    out  N   sticky pending vector (unmasked)
// ---------------------------------------------------------------------------
module irq_priority_encoder #(
   parameter  int unsigned N    = 8,
   parameter  int unsigned MODE = 0,
   localparam int unsigned W    = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] pending
);

   localparam int unsigned WE = W + 1;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t         r_state;
   logic [N-1:0]   r_pending;
   logic [W-1:0]   r_out_idx;
   logic           r_out_valid;
   logic [W-1:0]   r_rr_last;

   state_t         w_state_nxt;
   logic [N-1:0]   w_pending_nxt;
   logic [W-1:0]   w_out_idx_nxt;
   logic           w_out_valid_nxt;
   logic [W-1:0]   w_rr_last_nxt;

   logic           w_accept;
   logic [N-1:0]   w_clr;
   logic [N-1:0]   w_cand;
   logic           w_any;
   logic [W-1:0]   w_fixed_pick;
   logic [W-1:0]   w_rr_start;
   logic [2*N-1:0] w_cand2;
   logic [N-1:0]   w_rot;
   logic [W-1:0]   w_rot_off;
   logic [WE-1:0]  w_rr_sum;
   logic [W-1:0]   w_rr_pick;
   logic [W-1:0]   w_pick;

   // Capture/clear: clear of the accepted bit first, then a same-cycle request re-sets it
   always_comb begin
      w_accept      = r_out_valid & out_ready;
      w_clr         = '0;
      if (w_accept) begin
         w_clr = N'(1) << r_out_idx;
      end
      w_pending_nxt = (r_pending & ~w_clr) | req;
   end

   // Fixed priority: highest set candidate bit
   always_comb begin
      w_cand       = r_pending & mask;
      w_any        = |w_cand;
      w_fixed_pick = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (w_cand[i]) begin
            w_fixed_pick = W'(i);
         end
      end
   end

   // Round-robin: rotate candidates so bit 0 is the first searched position,
   // find the lowest set bit, then map the offset back modulo N
   always_comb begin
      w_rr_start = (r_rr_last == W'(N - 1)) ? '0 : r_rr_last + W'(1);
      w_cand2    = {w_cand, w_cand};
      w_rot      = N'(w_cand2 >> w_rr_start);
      w_rot_off  = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_rot_off = W'(i);
         end
      end
      w_rr_sum = WE'(w_rr_start) + WE'(w_rot_off);
      if (w_rr_sum >= WE'(N)) begin
         w_rr_sum = w_rr_sum - WE'(N);
      end
      w_rr_pick = w_rr_sum[W-1:0];
      w_pick    = (MODE == 0) ? w_fixed_pick : w_rr_pick;
   end

   // Grant FSM: present one grant and hold it until accepted
   always_comb begin
      w_state_nxt     = r_state;
      w_out_idx_nxt   = r_out_idx;
      w_out_valid_nxt = r_out_valid;
      w_rr_last_nxt   = r_rr_last;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_out_idx_nxt   = w_pick;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (w_accept) begin
               w_out_valid_nxt = 1'b0;
               w_rr_last_nxt   = r_out_idx;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_pending   <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_rr_last   <= W'(N - 1);
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_rr_last   <= w_rr_last_nxt;
      end
   end

   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;
   assign pending   = r_pending;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_encoder
//  Directed bench for irq_priority_encoder. Three instances:
//   a: N=8 fixed priority, b: N=8 round-robin, c: N=5 round-robin.
// ---------------------------------------------------------------------------
module tb_irq_priority_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // instance a: N=8, MODE=0
   logic       a_rst_n, a_ready, a_valid;
   logic [7:0] a_req, a_mask, a_pend;
   logic [2:0] a_idx;
   // instance b: N=8, MODE=1
   logic       b_rst_n, b_ready, b_valid;
   logic [7:0] b_req, b_mask, b_pend;
   logic [2:0] b_idx;
   // instance c: N=5, MODE=1
   logic       c_rst_n, c_ready, c_valid;
   logic [4:0] c_req, c_mask, c_pend;
   logic [2:0] c_idx;

   irq_priority_encoder #(.N(8), .MODE(0)) u_a (
      .clk(clk), .rst_n(a_rst_n), .req(a_req), .mask(a_mask),
      .out_idx(a_idx), .out_valid(a_valid), .out_ready(a_ready), .pending(a_pend));

   irq_priority_encoder #(.N(8), .MODE(1)) u_b (
      .clk(clk), .rst_n(b_rst_n), .req(b_req), .mask(b_mask),
      .out_idx(b_idx), .out_valid(b_valid), .out_ready(b_ready), .pending(b_pend));

   irq_priority_encoder #(.N(5), .MODE(1)) u_c (
      .clk(clk), .rst_n(c_rst_n), .req(c_req), .mask(c_mask),
      .out_idx(c_idx), .out_valid(c_valid), .out_ready(c_ready), .pending(c_pend));

   // Per-edge expectations for the one-shot 8'b0010_0110 request on instance a
   logic [7:0] t2_pend [8] = '{8'h26, 8'h26, 8'h06, 8'h06, 8'h02, 8'h02, 8'h00, 8'h00};
   logic       t2_v    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   int         t2_i    [8] = '{0, 5, 0, 2, 0, 1, 0, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      a_rst_n = 1'b0;
      a_req   = '0;
      tick();
      a_rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst_n = 1'b0; a_req = 8'hFF; a_mask = 8'hFF; a_ready = 1'b0;
      b_rst_n = 1'b0; b_req = 8'h00; b_mask = 8'hFF; b_ready = 1'b0;
      c_rst_n = 1'b0; c_req = 5'h00; c_mask = 5'h1F; c_ready = 1'b0;

      // Reset with all requests high, then 2-edge latency to grant 7
      tick(); tick();
      check("rst_pend",  32'(a_pend),  32'h00);
      check("rst_valid", 32'(a_valid), 32'h0);
      check("rst_idx",   32'(a_idx),   32'h0);
      a_rst_n = 1'b1;
      tick();
      check("lat1_valid", 32'(a_valid), 32'h0);
      check("lat1_pend",  32'(a_pend),  32'hFF);
      a_req = 8'h00;
      tick();
      check("lat2_valid", 32'(a_valid), 32'h1);
      check("lat2_idx",   32'(a_idx),   32'h7);

      // Fixed priority: 5, 2, 1 on alternate edges, then idle
      reset_a();
      a_mask = 8'hFF; a_ready = 1'b1; a_req = 8'h26;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) a_req = 8'h00;
         check($sformatf("fix_valid%0d", i), 32'(a_valid), 32'(t2_v[i]));
         if (t2_v[i]) check($sformatf("fix_idx%0d", i), 32'(a_idx), 32'(t2_i[i]));
         check($sformatf("fix_pend%0d", i), 32'(a_pend), 32'(t2_pend[i]));
      end

      // Stall: grant 3 held while req[7] pulses, then 7 follows
      reset_a();
      a_ready = 1'b0; a_req = 8'h08;
      tick();
      a_req = 8'h00;
      tick();
      check("stall_idx0",   32'(a_idx),   32'h3);
      check("stall_valid0", 32'(a_valid), 32'h1);
      for (int i = 0; i < 5; i++) begin
         a_req = (i % 2 == 0) ? 8'h80 : 8'h00;
         tick();
         check($sformatf("stall_idx%0d", i + 1),   32'(a_idx),   32'h3);
         check($sformatf("stall_valid%0d", i + 1), 32'(a_valid), 32'h1);
      end
      a_req = 8'h00; a_ready = 1'b1;
      tick();
      check("stall_acc_valid", 32'(a_valid), 32'h0);
      check("stall_acc_pend",  32'(a_pend),  32'h80);
      tick();
      check("stall_next_valid", 32'(a_valid), 32'h1);
      check("stall_next_idx",   32'(a_idx),   32'h7);
      a_ready = 1'b0;

      // Set beats clear on the accept edge
      reset_a();
      a_ready = 1'b0; a_req = 8'h10;
      tick();
      a_req = 8'h00;
      tick();
      check("svc_idx0", 32'(a_idx), 32'h4);
      a_req = 8'h10; a_ready = 1'b1;
      tick();
      check("svc_acc_valid", 32'(a_valid), 32'h0);
      check("svc_acc_pend",  32'(a_pend),  32'h10);
      a_req = 8'h00;
      tick();
      check("svc_regrant_valid", 32'(a_valid), 32'h1);
      check("svc_regrant_idx",   32'(a_idx),   32'h4);
      tick();
      check("svc_drain_pend", 32'(a_pend), 32'h00);

      // Masked source stays pending and is not granted until unmasked
      a_mask = 8'hFB; a_req = 8'h04;
      tick();
      a_req = 8'h00;
      check("mask_pend0", 32'(a_pend), 32'h04);
      tick(); tick(); tick();
      check("mask_valid", 32'(a_valid), 32'h0);
      check("mask_pend1", 32'(a_pend),  32'h04);
      a_mask = 8'hFF;
      tick();
      check("unmask_valid", 32'(a_valid), 32'h1);
      check("unmask_idx",   32'(a_idx),   32'h2);

      // Round-robin N=8: 0..7,0 with all requests held, then mask 0x81 alternates
      b_rst_n = 1'b1; b_req = 8'hFF; b_ready = 1'b1; b_mask = 8'hFF;
      tick(); tick();
      for (int k = 0; k < 9; k++) begin
         check($sformatf("rr_valid%0d", k), 32'(b_valid), 32'h1);
         check($sformatf("rr_idx%0d", k),   32'(b_idx),   32'(k % 8));
         if (k == 8) b_mask = 8'h81;
         tick();
         check($sformatf("rr_gap%0d", k), 32'(b_valid), 32'h0);
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         check($sformatf("rrm_valid%0d", j), 32'(b_valid), 32'h1);
         check($sformatf("rrm_idx%0d", j),   32'(b_idx),   (j % 2 == 0) ? 32'h7 : 32'h0);
         tick(); tick();
      end

      // N=5 round-robin: reset mid-PRESENT, then a full wrap
      c_rst_n = 1'b1; c_req = 5'h1F; c_ready = 1'b1;
      tick(); tick();
      check("c_first_idx", 32'(c_idx), 32'h0);
      tick();
      check("c_acc_valid", 32'(c_valid), 32'h0);
      c_ready = 1'b0;
      tick();
      check("c_pres_idx",   32'(c_idx),   32'h1);
      check("c_pres_valid", 32'(c_valid), 32'h1);
      tick();
      check("c_hold_idx", 32'(c_idx), 32'h1);
      #1 c_rst_n = 1'b0;
      #1;
      check("c_rst_valid", 32'(c_valid), 32'h0);
      check("c_rst_idx",   32'(c_idx),   32'h0);
      check("c_rst_pend",  32'(c_pend),  32'h00);
      tick();
      check("c_rst_hold_pend", 32'(c_pend), 32'h00);
      c_rst_n = 1'b1; c_ready = 1'b1;
      tick(); tick();
      for (int k = 0; k < 7; k++) begin
         check($sformatf("c_wrap_valid%0d", k), 32'(c_valid), 32'h1);
         check($sformatf("c_wrap_idx%0d", k),   32'(c_idx),   32'(k % 5));
         check($sformatf("c_wrap_range%0d", k), 32'(c_idx < 3'd5), 32'h1);
         tick(); tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
